// File: rtl/bcd_seg_display_pkg.sv
// Shared constants, glyph table and FSM state type for the BCD seven-segment display.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_seg_display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Glyphs for nibble values 0..F; listed from F down to 0 so index n holds glyph n
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08,        // F E d C b A
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19,        // 9 8 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40                       // 3 2 1 0
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bcd_seg_display_seg7_decode.sv
// Nibble to active-low seven-segment glyph (0-9, A-F).
// Latency: combinational.
// Backpressure: none.
module seg7_decode
  import bcd_seg_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[nib];

endmodule

// File: rtl/bcd_seg_display.sv
// Iterative value-to-seven-segment converter (double dabble in decimal, plain shift in hex).
// Latency: start accepted at edge E0, seg/overflow/done update at edge E(WIDTH+1).
// Backpressure: start is ignored while busy=1; nothing is queued.
module bcd_seg_display
  import bcd_seg_display_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  dec_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CW = clog2(WIDTH + 1);
  localparam int DW = 4 * DIGITS;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  val_q;
  logic [DW-1:0]     dig_q;
  logic [DW-1:0]     dig_adj;
  logic [DW-1:0]     dig_nxt;
  logic              dec_q;
  logic              ovf_sticky;
  logic [CW-1:0]     cnt_q;
  logic              busy_d, done_d;
  logic              accept, shift_en, out_en;
  logic [6:0]        glyph [DIGITS];
  logic [7*DIGITS-1:0] seg_nxt;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-state control strobes
  always_comb begin
    state_d  = state_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    accept   = 1'b0;
    shift_en = 1'b0;
    out_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy_d   = 1'b1;
        shift_en = 1'b1;
        if (cnt_q == CW'(1)) state_d = LOAD;
      end
      LOAD: begin
        out_en  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on nibbles >= 5 before each shift; skipped in hex so latency is identical
  always_comb begin
    dig_adj = dig_q;
    if (dec_q) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (dig_q[4*k +: 4] >= 4'd5) dig_adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Digit register takes the value MSB; its own MSB falls off and feeds the sticky overflow
  assign dig_nxt = {dig_adj[DW-2:0], val_q[WIDTH-1]};

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dec
      seg7_decode u_dec (
        .nib (dig_q[4*g +: 4]),
        .seg (glyph[g])
      );
    end
  endgenerate

  // Final glyph selection: dashes on overflow, otherwise glyphs with optional leading-zero blanking
  always_comb begin
    logic hi_zero;
    seg_nxt = '1;
    hi_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero && (dig_q[4*k +: 4] == 4'd0);
      if (ovf_sticky)
        seg_nxt[7*k +: 7] = SEG_DASH;
      else if ((BLANK_LZ != 0) && (k > 0) && hi_zero)
        seg_nxt[7*k +: 7] = SEG_BLANK;
      else
        seg_nxt[7*k +: 7] = glyph[k];
    end
  end

  // Conversion datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q      <= '0;
      dig_q      <= '0;
      dec_q      <= 1'b0;
      ovf_sticky <= 1'b0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      seg        <= '1;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (accept) begin
        val_q      <= value;
        dec_q      <= dec_mode;
        dig_q      <= '0;
        ovf_sticky <= 1'b0;
        cnt_q      <= CW'(WIDTH);
      end else if (shift_en) begin
        val_q      <= val_q << 1;
        dig_q      <= dig_nxt;
        ovf_sticky <= ovf_sticky | dig_adj[DW-1];
        cnt_q      <= cnt_q - CW'(1);
      end
      if (out_en) begin
        seg      <= seg_nxt;
        overflow <= ovf_sticky;
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Scoreboard bench for bcd_seg_display: three instances (default, no blanking, two digits).
// Latency: expects done WIDTH+1 edges after the accepting edge.
// Backpressure: checks that start during busy is dropped, not queued.
module tb_bcd_seg_display;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  start;
  logic [7:0]  val [3];
  logic [2:0]  dec;
  logic [2:0]  busy, done, ovf;
  logic [20:0] seg0, seg1;
  logic [13:0] seg2;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    logic [21:0] res;
    int          cyc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_seg_display u0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .value(val[0]), .dec_mode(dec[0]),
    .busy(busy[0]), .done(done[0]), .overflow(ovf[0]), .seg(seg0));

  bcd_seg_display #(.BLANK_LZ(0)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .value(val[1]), .dec_mode(dec[1]),
    .busy(busy[1]), .done(done[1]), .overflow(ovf[1]), .seg(seg1));

  bcd_seg_display #(.DIGITS(2)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .value(val[2]), .dec_mode(dec[2]),
    .busy(busy[2]), .done(done[2]), .overflow(ovf[2]), .seg(seg2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Reference: arithmetic digit extraction, result packed as {overflow, seg}
  function automatic logic [21:0] model(input int v, input bit d, input int nd, input bit blz);
    int          base, lim, r;
    int          dig [3];
    logic [20:0] s;
    bit          o, hi_zero;
    base = d ? 10 : 16;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * base;
    o = (v >= lim);
    r = v;
    for (int k = 0; k < 3; k++) begin
      dig[k] = r % base;
      r = r / base;
    end
    s = '0;
    hi_zero = 1'b1;
    for (int k = nd - 1; k >= 0; k--) begin
      hi_zero = hi_zero && (dig[k] == 0);
      if (o)                          s[7*k +: 7] = 7'b0111111;
      else if (blz && k > 0 && hi_zero) s[7*k +: 7] = 7'b1111111;
      else                            s[7*k +: 7] = glyph(dig[k]);
    end
    return {o, s};
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic score(input int i, input logic [21:0] got);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      chk($sformatf("u%0d_unexpected_done", i), {31'b0, done[i]}, 32'd0);
    end else begin
      chk($sformatf("u%0d_result", i), {10'b0, got}, {10'b0, e.res});
      chk($sformatf("u%0d_latency", i), cyc, e.cyc);
      chk($sformatf("u%0d_busy_fall", i), {31'b0, busy[i]}, 32'd0);
    end
  endtask

  // Compare every done pulse against the scoreboard
  always @(negedge clk) begin
    if (done[0]) score(0, {ovf[0], seg0});
    if (done[1]) score(1, {ovf[1], seg1});
    if (done[2]) score(2, {ovf[2], 7'b0, seg2});
  end

  task automatic conv(input int i, input logic [7:0] v, input bit d);
    exp_t e;
    @(negedge clk);
    start[i] = 1'b1;
    val[i]   = v;
    dec[i]   = d;
    @(posedge clk);
    #1;
    e.res = model(int'(v), d, (i == 2) ? 2 : 3, (i == 1) ? 1'b0 : 1'b1);
    e.cyc = cyc + 9;
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    chk($sformatf("u%0d_busy_rise", i), {31'b0, busy[i]}, 32'd1);
    @(negedge clk);
    start[i] = 1'b0;
    val[i]   = 8'($urandom);
    dec[i]   = 1'($urandom);
  endtask

  task automatic drain(input int i);
    bit empty;
    empty = 1'b0;
    for (int t = 0; t < 40 && !empty; t++) begin
      @(negedge clk);
      #1;
      empty = (qsize(i) == 0);
    end
    if (!empty) chk($sformatf("u%0d_done_timeout", i), qsize(i), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start   = '0;
    dec     = '0;
    for (int i = 0; i < 3; i++) val[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {29'b0, busy}, 32'd0);
    chk("rst_done", {29'b0, done}, 32'd0);
    chk("rst_ovf", {29'b0, ovf}, 32'd0);
    chk("rst_seg0", {11'b0, seg0}, 32'h1FFFFF);
    chk("rst_seg2", {18'b0, seg2}, 32'h3FFF);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    conv(0, 8'd255, 1'b1);  drain(0);
    conv(0, 8'd7, 1'b1);    drain(0);
    conv(1, 8'd7, 1'b1);    drain(1);
    conv(0, 8'hAB, 1'b0);   drain(0);
    conv(0, 8'd0, 1'b1);    drain(0);
    conv(2, 8'd99, 1'b1);   drain(2);
    conv(2, 8'd150, 1'b1);  drain(2);
    conv(2, 8'd150, 1'b0);  drain(2);
    conv(1, 8'd255, 1'b0);  drain(1);

    // A second request held high while busy is dropped, not queued
    conv(0, 8'd12, 1'b1);
    start[0] = 1'b1;
    val[0]   = 8'd200;
    dec[0]   = 1'b1;
    repeat (5) @(negedge clk);
    start[0] = 1'b0;
    drain(0);
    repeat (12) @(negedge clk);
    conv(0, 8'd200, 1'b1);  drain(0);

    // Reset during the fourth shift aborts with no done pulse
    conv(0, 8'd255, 1'b1);  drain(0);
    @(negedge clk);
    start[0] = 1'b1;
    val[0]   = 8'd100;
    dec[0]   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", {31'b0, busy[0]}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy[0]}, 32'd0);
    chk("abort_done", {31'b0, done[0]}, 32'd0);
    chk("abort_ovf", {31'b0, ovf[0]}, 32'd0);
    chk("abort_seg", {11'b0, seg0}, 32'h1FFFFF);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    conv(0, 8'd42, 1'b1);   drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_seg_display.md
Name: bcd_seg_display

Overview:
- Parametrised, sequential successor to the two-digit combinational hex-to-decimal display decoder.
- Converts a WIDTH-bit unsigned value to DIGITS active-low seven-segment digits, in decimal or hexadecimal mode.
- Decimal conversion is iterative shift-add-3 (double dabble), one bit per clock, with a start/busy/done handshake.
- Sits between the battle datapath (HP, damage, accuracy values) and the HEX outputs; each instance drives a group of digits.

Parameters:
- WIDTH, 8, bit width of the input value (>= 1).
- DIGITS, 3, number of seven-segment digits driven (>= 1).
- BLANK_LZ, 1, when 1, leading zero digits are blanked (digit 0 is never blanked).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; accepted only when busy=0.
- value  input  WIDTH  unsigned value to display; sampled on the accepting edge.
- dec_mode  input  1  1=decimal, 0=hexadecimal; sampled on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when seg/overflow are updated.
- overflow  output  1  result did not fit in DIGITS digits; held with seg.
- seg  output  7*DIGITS  active-low segments; digit k at [7k+6:7k], bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, reset_n=0): busy=0, done=0, overflow=0, seg all ones (all digits blank), FSM to IDLE, internal registers cleared.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE: on start=1, latch value into shift register, latch dec_mode, clear the 4*DIGITS-bit digit register and the sticky overflow bit, set bit counter=WIDTH, busy=1, go to SHIFT.
- SHIFT, one edge per iteration:
  - if the latched mode is decimal, add 3 to every digit nibble >= 5;
  - shift {digit register, value register} left by 1;
  - a 1 shifted out of the digit register MSB sets the sticky overflow bit;
  - decrement the counter; after the WIDTH-th shift go to LOAD.
- Hex mode uses the same path with add-3 disabled, so hex and decimal latency are identical.
- LOAD, one edge:
  - register seg from the digit register; register overflow from the sticky bit;
  - done=1 for exactly this cycle; busy=0; go to IDLE.
- Latency: start accepted at edge E0; seg, overflow and done update at edge E(WIDTH+1). Next start is accepted at the earliest on the edge after done.
- start while busy=1: ignored, no queueing. start held high re-triggers a conversion each time IDLE is entered.
- value and dec_mode changes after the accepting edge have no effect on the current conversion.
- seg and overflow hold their last values between conversions.
- Overflow display: when overflow=1, every digit shows a dash (segment g only, 7'b0111111).
- Decode: 0-9 use standard glyphs (0 = 7'b1000000). Hex A-F: A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
- Leading-zero blanking (BLANK_LZ=1, no overflow): digit k>0 is blank (7'b1111111) iff digits k..DIGITS-1 are all zero.
- Reset mid-conversion: abort immediately to reset values; no done pulse.

Decomposition:
- Shared package:
  - segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F;
  - a 16-entry glyph table;
  - FSM state typedef (IDLE/SHIFT/LOAD);
  - counter width helper function clog2(WIDTH+1).
- Sub-module seg7_decode: combinational nibble to active-low segments, instantiated DIGITS times via generate.

Test Plan:
- Defaults, dec_mode=1, value=255, start pulse: busy rises on the accepting edge; done pulses 9 cycles later; digits "2","5","5"; overflow=0.
- Defaults, dec_mode=1, value=7: digit0 "7" (1111000); digits 1 and 2 blank (7F). Repeat with BLANK_LZ=0: digits 1 and 2 show "0" (1000000).
- Defaults, dec_mode=0, value=8'hAB: digit0 "b" (0000011), digit1 "A" (0001000), digit2 blank; latency again 9 cycles.
- WIDTH=8, DIGITS=2:
  - decimal 99 gives "99", overflow=0;
  - decimal 150 gives overflow=1 with both digits 0111111;
  - hex 150 (0x96) gives "9","6", overflow=0.
- Start pulse with value=12, then start with value=200 held high while busy: the second request is ignored; done shows "12"; a request issued after done yields "200".
- Convert 255, then start 100 and drop reset_n at SHIFT iteration 4: outputs return immediately to reset values (all blank, busy=0), no done pulse; a fresh conversion of 42 after release gives "42".
